// File: rtl/core_mem_arb_pkg.sv
// Shared constants and types for the core memory arbiter: FSM encodings,
// port indices, the latched request record and the fixed read-data values.
package core_mem_arb_pkg;

  // FSM encodings (kept as plain constants for compatibility with older tools)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;

  // Port indices into the per-port request latch array
  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  // Read data returned on an aborted access, and the fetch data after reset (NOP)
  localparam logic [31:0] TIMEOUT_RDATA    = 32'hDEADBEEF;
  localparam logic [31:0] IMEM_RESET_RDATA = 32'h0000_0013;

  // Everything needed to replay a request on the shared bus
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } mem_req_t;

  // 3-bit saturating increment for the data-streak counter
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'b111) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/core_mem_arb_if.sv
// External memory bus: a valid/ready handshake with address, write data and
// byte strobes towards the slave, read data back alongside READY.
interface core_mem_arb_if;
  logic        BUS_VALID;
  logic        BUS_WRITE;
  logic [31:0] BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic [3:0]  BUS_STRB;
  logic        BUS_READY;
  logic [31:0] BUS_RDATA;

  modport master (
    output BUS_VALID, BUS_WRITE, BUS_ADDR, BUS_WDATA, BUS_STRB,
    input  BUS_READY, BUS_RDATA
  );

  modport slave (
    input  BUS_VALID, BUS_WRITE, BUS_ADDR, BUS_WDATA, BUS_STRB,
    output BUS_READY, BUS_RDATA
  );
endinterface

// File: rtl/core_mem_arb_req_latch.sv
// Per-port request latch: turns a one-cycle request pulse into a pending flag
// and holds the request fields until the arbiter completes the access.
module core_mem_arb_req_latch
  import core_mem_arb_pkg::*;
(
  input  logic     CLK,
  input  logic     NRST,
  input  logic     req,
  input  mem_req_t req_info,
  input  logic     clr,
  output logic     pending,
  output logic     pending_next,
  output mem_req_t info
);

  logic     pending_reg;
  mem_req_t info_reg;
  logic     accept;

  // A pulse is taken when the port is idle, or in the very cycle its current
  // access completes, so a port can stream requests without a bus bubble.
  // Any other pulse while pending is dropped.
  assign accept       = req & (~pending_reg | clr);
  assign pending_next = accept | (pending_reg & ~clr);

  // Pending flag and captured request fields
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      pending_reg <= 1'b0;
      info_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (accept) begin
        info_reg <= req_info;
      end
    end
  end

  assign pending = pending_reg;
  assign info    = info_reg;

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one external memory bus between instruction fetch and data
// load/store. Data has priority, but a pending fetch is forced through after
// MAX_DSTREAK back-to-back data grants. Accesses stalled for TIMEOUT cycles
// are aborted with a poison read value and a sticky timeout flag.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        NRST,
  // instruction fetch port
  input  logic        IMEM_REQ,
  input  logic [31:0] IMEM_ADDR,
  output logic [31:0] IMEM_RDATA,
  output logic        HCU_IMEM_BUSY,
  output logic        HCU_IMEM_DONE,
  // data load/store port
  input  logic        DMEM_REQ_LOAD,
  input  logic        DMEM_REQ_STORE,
  input  logic [31:0] DMEM_ADDR,
  input  logic [31:0] DMEM_WDATA,
  input  logic [3:0]  DMEM_STRB,
  output logic [31:0] DMEM_RDATA,
  output logic        HCU_DMEM_BUSY,
  output logic        HCU_DMEM_DONE,
  // shared bus
  core_mem_arb_if.master bus,
  output logic        BUS_TIMEOUT
);

  localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0] DSTREAK_MAX = 3'(MAX_DSTREAK);

  logic [1:0] state_reg, state_next;
  logic [2:0] dstreak_reg, dstreak_next;
  logic [7:0] wait_reg, wait_next;
  logic       done_i_reg, done_d_reg;
  logic       timeout_reg;
  logic [31:0] imem_rdata_reg, dmem_rdata_reg;

  logic [1:0] pulse, clr, pend, pend_next;
  mem_req_t   req_info [2];
  mem_req_t   info     [2];
  mem_req_t   sel;

  logic granted, gnt_i, gnt_d;
  logic handshake, abort, finish, decide;
  logic req_i, req_d;

  // Request records as seen by each latch; a store beats a simultaneous load
  assign pulse[PORT_I]    = IMEM_REQ;
  assign pulse[PORT_D]    = DMEM_REQ_LOAD | DMEM_REQ_STORE;
  assign req_info[PORT_I] = '{write: 1'b0, addr: IMEM_ADDR, wdata: 32'd0, strb: 4'd0};
  assign req_info[PORT_D] = '{write: DMEM_REQ_STORE, addr: DMEM_ADDR, wdata: DMEM_WDATA,
                              strb: DMEM_REQ_STORE ? DMEM_STRB : 4'd0};

  assign gnt_i   = (state_reg == ST_GNT_I);
  assign gnt_d   = (state_reg == ST_GNT_D);
  assign granted = gnt_i | gnt_d;

  // An access ends either by handshake or by running out of wait cycles
  assign handshake = granted & bus.BUS_READY;
  assign abort     = granted & ~bus.BUS_READY & (wait_reg == WAIT_LAST);
  assign finish    = handshake | abort;
  assign clr[PORT_I] = gnt_i & finish;
  assign clr[PORT_D] = gnt_d & finish;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      core_mem_arb_req_latch u_latch (
        .CLK          (CLK),
        .NRST         (NRST),
        .req          (pulse[gi]),
        .req_info     (req_info[gi]),
        .clr          (clr[gi]),
        .pending      (pend[gi]),
        .pending_next (pend_next[gi]),
        .info         (info[gi])
      );
    end
  endgenerate

  // Arbitration looks at what will be pending after this edge, which folds in
  // this cycle's pulses and drops the access that is just completing.
  assign req_i  = pend_next[PORT_I];
  assign req_d  = pend_next[PORT_D];
  assign decide = (state_reg == ST_IDLE) | finish;

  // Next grant and data-streak bookkeeping
  always_comb begin
    state_next   = state_reg;
    dstreak_next = dstreak_reg;
    if (decide) begin
      if (req_d && !(req_i && (dstreak_reg >= DSTREAK_MAX))) begin
        state_next   = ST_GNT_D;
        dstreak_next = sat_inc3(dstreak_reg);
      end else if (req_i) begin
        state_next   = ST_GNT_I;
        dstreak_next = 3'd0;
      end else begin
        state_next   = ST_IDLE;
      end
    end
    if (!req_i) begin
      dstreak_next = 3'd0;
    end
  end

  // Wait counter restarts with every grant and counts stalled bus cycles
  always_comb begin
    wait_next = wait_reg;
    if (decide) begin
      wait_next = 8'd0;
    end else if (granted && !bus.BUS_READY) begin
      wait_next = wait_reg + 8'd1;
    end
  end

  // FSM, streak and wait counter registers
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_reg   <= ST_IDLE;
      dstreak_reg <= 3'd0;
      wait_reg    <= 8'd0;
    end else begin
      state_reg   <= state_next;
      dstreak_reg <= dstreak_next;
      wait_reg    <= wait_next;
    end
  end

  // Completion pulses, returned read data and the sticky timeout flag
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      done_i_reg     <= 1'b0;
      done_d_reg     <= 1'b0;
      timeout_reg    <= 1'b0;
      imem_rdata_reg <= IMEM_RESET_RDATA;
      dmem_rdata_reg <= 32'd0;
    end else begin
      done_i_reg  <= clr[PORT_I];
      done_d_reg  <= clr[PORT_D];
      timeout_reg <= timeout_reg | abort;
      if (clr[PORT_I]) begin
        imem_rdata_reg <= abort ? TIMEOUT_RDATA : bus.BUS_RDATA;
      end
      if (clr[PORT_D]) begin
        if (abort) begin
          dmem_rdata_reg <= TIMEOUT_RDATA;
        end else if (!info[PORT_D].write) begin
          dmem_rdata_reg <= bus.BUS_RDATA;
        end
      end
    end
  end

  // Bus fields come straight from the granted latch; decoding them from the
  // state register lets reset drop BUS_VALID without waiting for a clock.
  assign sel           = gnt_d ? info[PORT_D] : info[PORT_I];
  assign bus.BUS_VALID = granted;
  assign bus.BUS_WRITE = granted & sel.write;
  assign bus.BUS_ADDR  = granted ? sel.addr  : 32'd0;
  assign bus.BUS_WDATA = granted ? sel.wdata : 32'd0;
  assign bus.BUS_STRB  = granted ? sel.strb  : 4'd0;

  assign HCU_IMEM_BUSY = pend[PORT_I] | pulse[PORT_I];
  assign HCU_DMEM_BUSY = pend[PORT_D] | pulse[PORT_D];
  assign HCU_IMEM_DONE = done_i_reg;
  assign HCU_DMEM_DONE = done_d_reg;
  assign IMEM_RDATA    = imem_rdata_reg;
  assign DMEM_RDATA    = dmem_rdata_reg;
  assign BUS_TIMEOUT   = timeout_reg;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: a transaction-level model tracks who owns the
// bus and what each port has outstanding; every falling edge the DUT outputs
// are compared with it, and directed scenarios add hand-computed checks.
module tb_core_mem_arbiter;
  import core_mem_arb_pkg::*;

  localparam int          MAXD   = 4;
  localparam int          TMO    = 255;
  localparam logic [31:0] RD_XOR = 32'h5A5A_0000;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic        IMEM_REQ = 1'b0;
  logic [31:0] IMEM_ADDR = 32'd0;
  logic [31:0] IMEM_RDATA;
  logic        HCU_IMEM_BUSY, HCU_IMEM_DONE;
  logic        DMEM_REQ_LOAD = 1'b0;
  logic        DMEM_REQ_STORE = 1'b0;
  logic [31:0] DMEM_ADDR = 32'd0;
  logic [31:0] DMEM_WDATA = 32'd0;
  logic [3:0]  DMEM_STRB = 4'd0;
  logic [31:0] DMEM_RDATA;
  logic        HCU_DMEM_BUSY, HCU_DMEM_DONE;
  logic        BUS_TIMEOUT;
  logic        ready = 1'b0;

  always #5 CLK = ~CLK;

  core_mem_arb_if bus ();
  // Slave returns a read value derived from the address it is shown
  assign bus.BUS_READY = ready;
  assign bus.BUS_RDATA = bus.BUS_ADDR ^ RD_XOR;

  core_mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .CLK            (CLK),
    .NRST           (NRST),
    .IMEM_REQ       (IMEM_REQ),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_RDATA     (IMEM_RDATA),
    .HCU_IMEM_BUSY  (HCU_IMEM_BUSY),
    .HCU_IMEM_DONE  (HCU_IMEM_DONE),
    .DMEM_REQ_LOAD  (DMEM_REQ_LOAD),
    .DMEM_REQ_STORE (DMEM_REQ_STORE),
    .DMEM_ADDR      (DMEM_ADDR),
    .DMEM_WDATA     (DMEM_WDATA),
    .DMEM_STRB      (DMEM_STRB),
    .DMEM_RDATA     (DMEM_RDATA),
    .HCU_DMEM_BUSY  (HCU_DMEM_BUSY),
    .HCU_DMEM_DONE  (HCU_DMEM_DONE),
    .bus            (bus),
    .BUS_TIMEOUT    (BUS_TIMEOUT)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_own: -1 bus free, 0 fetch owns it, 1 data owns it
  bit          m_pend  [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_strb  [2];
  bit          m_wr    [2];
  bit          m_done  [2];
  logic [31:0] m_rdata [2];
  int          m_own, m_streak, m_wait;
  bit          m_tmo;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_addr[k] = 0; m_wdata[k] = 0; m_strb[k] = 0;
      m_wr[k] = 0; m_done[k] = 0;
    end
    m_rdata[0] = 32'h13;
    m_rdata[1] = 32'h0;
    m_own = -1; m_streak = 0; m_wait = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    bit fin, ab;
    bit pl [2];
    int o;
    pl[0] = IMEM_REQ;
    pl[1] = DMEM_REQ_LOAD | DMEM_REQ_STORE;
    o = m_own;
    fin = 0; ab = 0;
    if (o >= 0) begin
      if (ready) fin = 1;
      else if (m_wait + 1 >= TMO) begin fin = 1; ab = 1; end
    end
    m_done[0] = 0; m_done[1] = 0;
    if (fin) begin
      m_done[o] = 1;
      if (ab) begin m_rdata[o] = 32'hDEADBEEF; m_tmo = 1; end
      else if (!m_wr[o]) m_rdata[o] = m_addr[o] ^ RD_XOR;
      m_pend[o] = 0;
    end
    // a port whose access just finished may take a new request at once
    if (pl[0] && !m_pend[0]) begin
      m_pend[0] = 1; m_addr[0] = IMEM_ADDR; m_wdata[0] = 0; m_strb[0] = 0; m_wr[0] = 0;
    end
    if (pl[1] && !m_pend[1]) begin
      m_pend[1] = 1; m_addr[1] = DMEM_ADDR; m_wdata[1] = DMEM_WDATA;
      m_wr[1] = DMEM_REQ_STORE; m_strb[1] = DMEM_REQ_STORE ? DMEM_STRB : 4'd0;
    end
    if (o < 0 || fin) begin
      m_wait = 0;
      if (m_pend[1] && !(m_pend[0] && m_streak >= MAXD)) begin
        m_own = 1;
        m_streak = m_pend[0] ? ((m_streak < 7) ? m_streak + 1 : 7) : 0;
      end else if (m_pend[0]) begin
        m_own = 0; m_streak = 0;
      end else begin
        m_own = -1;
      end
    end else if (!ready) begin
      m_wait = m_wait + 1;
    end
    if (!m_pend[0]) m_streak = 0;
  endtask

  always @(posedge CLK or negedge NRST) begin
    if (!NRST) model_reset();
    else model_step();
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge CLK) begin
    bit v;
    v = (m_own >= 0);
    chk1("bus_valid", bus.BUS_VALID, v);
    chk1("bus_write", bus.BUS_WRITE, v ? m_wr[m_own] : 1'b0);
    chk("bus_addr",  bus.BUS_ADDR,  v ? m_addr[m_own]  : 32'd0);
    chk("bus_wdata", bus.BUS_WDATA, v ? m_wdata[m_own] : 32'd0);
    chk("bus_strb",  {28'd0, bus.BUS_STRB}, v ? {28'd0, m_strb[m_own]} : 32'd0);
    chk1("imem_busy", HCU_IMEM_BUSY, m_pend[0] | IMEM_REQ);
    chk1("dmem_busy", HCU_DMEM_BUSY, m_pend[1] | DMEM_REQ_LOAD | DMEM_REQ_STORE);
    chk1("imem_done", HCU_IMEM_DONE, m_done[0]);
    chk1("dmem_done", HCU_DMEM_DONE, m_done[1]);
    chk("imem_rdata", IMEM_RDATA, m_rdata[0]);
    chk("dmem_rdata", DMEM_RDATA, m_rdata[1]);
    chk1("bus_timeout", BUS_TIMEOUT, m_tmo);
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge CLK); #1;
    IMEM_REQ = 0; DMEM_REQ_LOAD = 0; DMEM_REQ_STORE = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, vcnt, ld;
    bit seen;
    logic [31:0] exp_addr [8];
    exp_addr = '{32'd0, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h300, 32'h1010, 32'h1014};

    // reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_imem_rdata", IMEM_RDATA, 32'h13);
    chk("rst_dmem_rdata", DMEM_RDATA, 32'h0);
    chk1("rst_valid", bus.BUS_VALID, 1'b0);
    @(posedge CLK); #1 NRST = 1;
    nxt();

    // single fetch, ready in the first valid cycle
    ready = 1; IMEM_REQ = 1; IMEM_ADDR = 32'h100;
    @(negedge CLK); chk1("f_busy_c0", HCU_IMEM_BUSY, 1'b1); chk1("f_valid_c0", bus.BUS_VALID, 1'b0);
    nxt();
    @(negedge CLK); chk1("f_valid_c1", bus.BUS_VALID, 1'b1); chk("f_addr_c1", bus.BUS_ADDR, 32'h100);
    chk1("f_write_c1", bus.BUS_WRITE, 1'b0); chk1("f_busy_c1", HCU_IMEM_BUSY, 1'b1);
    nxt();
    @(negedge CLK); chk1("f_done_c2", HCU_IMEM_DONE, 1'b1); chk("f_rdata_c2", IMEM_RDATA, 32'h5A5A_0100);
    chk1("f_busy_c2", HCU_IMEM_BUSY, 1'b0);
    nxt();

    // simultaneous fetch and store: store first, fetch right behind it
    IMEM_REQ = 1; IMEM_ADDR = 32'h200;
    DMEM_REQ_STORE = 1; DMEM_ADDR = 32'h2000; DMEM_WDATA = 32'hCAFE_F00D; DMEM_STRB = 4'b0011;
    nxt();
    @(negedge CLK); chk1("sf_write_c1", bus.BUS_WRITE, 1'b1); chk("sf_addr_c1", bus.BUS_ADDR, 32'h2000);
    chk("sf_strb_c1", {28'd0, bus.BUS_STRB}, 32'h3); chk("sf_wdata_c1", bus.BUS_WDATA, 32'hCAFE_F00D);
    nxt();
    @(negedge CLK); chk("sf_addr_c2", bus.BUS_ADDR, 32'h200); chk1("sf_valid_c2", bus.BUS_VALID, 1'b1);
    chk1("sf_ddone_c2", HCU_DMEM_DONE, 1'b1); chk("sf_drdata_c2", DMEM_RDATA, 32'h0);
    nxt();
    @(negedge CLK); chk1("sf_idone_c3", HCU_IMEM_DONE, 1'b1); chk("sf_irdata_c3", IMEM_RDATA, 32'h5A5A_0200);
    nxt();

    // pending fetch against a stream of six loads: fetch after four data grants
    ld = 0;
    for (int c = 0; c <= 8; c++) begin
      if (c == 0) begin IMEM_REQ = 1; IMEM_ADDR = 32'h300; end
      if (c <= 4 || c == 6) begin
        DMEM_REQ_LOAD = 1; DMEM_ADDR = 32'h1000 + 32'(4 * ld); ld++;
      end
      @(negedge CLK);
      if (c >= 1 && c <= 7) chk("streak_addr", bus.BUS_ADDR, exp_addr[c]);
      if (c == 8) begin
        chk1("streak_idle", bus.BUS_VALID, 1'b0);
        chk("streak_drdata", DMEM_RDATA, 32'h5A5A_1014);
      end
      nxt();
    end

    // second fetch request while one is pending is dropped
    ready = 0; hs = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) begin IMEM_REQ = 1; IMEM_ADDR = 32'h400; end
      if (c == 2) begin IMEM_REQ = 1; IMEM_ADDR = 32'h500; end
      if (c == 3) ready = 1;
      @(negedge CLK);
      if (bus.BUS_VALID && ready) hs++;
      if (c == 3) chk("dup_addr", bus.BUS_ADDR, 32'h400);
      nxt();
    end
    chk("dup_handshakes", 32'(hs), 32'd1);
    chk("dup_rdata", IMEM_RDATA, 32'h5A5A_0400);

    // load and store together: one write access only
    hs = 0;
    for (int c = 0; c <= 4; c++) begin
      if (c == 0) begin
        DMEM_REQ_LOAD = 1; DMEM_REQ_STORE = 1; DMEM_ADDR = 32'h3000;
        DMEM_WDATA = 32'h1122_3344; DMEM_STRB = 4'hF;
      end
      @(negedge CLK);
      if (bus.BUS_VALID && ready) hs++;
      if (c == 1) begin
        chk1("ls_write", bus.BUS_WRITE, 1'b1);
        chk("ls_strb", {28'd0, bus.BUS_STRB}, 32'hF);
      end
      nxt();
    end
    chk("ls_handshakes", 32'(hs), 32'd1);
    chk("ls_drdata", DMEM_RDATA, 32'h5A5A_1014);

    // ready held low: abort after 255 wait cycles
    ready = 0; vcnt = 0; seen = 0;
    DMEM_REQ_LOAD = 1; DMEM_ADDR = 32'h4000;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge CLK);
      if (bus.BUS_VALID) vcnt++;
      if (HCU_DMEM_DONE) begin
        seen = 1;
        chk("tmo_rdata", DMEM_RDATA, 32'hDEADBEEF);
        chk1("tmo_flag", BUS_TIMEOUT, 1'b1);
        chk1("tmo_valid_dropped", bus.BUS_VALID, 1'b0);
      end
      nxt();
    end
    chk1("tmo_done_seen", seen, 1'b1);
    chk("tmo_valid_cycles", 32'(vcnt), 32'd255);
    ready = 1; IMEM_REQ = 1; IMEM_ADDR = 32'h600;
    repeat (3) nxt();
    @(negedge CLK);
    chk1("tmo_sticky", BUS_TIMEOUT, 1'b1);
    chk("tmo_after_fetch", IMEM_RDATA, 32'h5A5A_0600);
    nxt();

    // reset during a stalled data grant
    ready = 0;
    DMEM_REQ_STORE = 1; DMEM_ADDR = 32'h5000; DMEM_WDATA = 32'h55AA_55AA; DMEM_STRB = 4'h5;
    repeat (3) nxt();
    @(negedge CLK); chk1("rst_mid_valid_before", bus.BUS_VALID, 1'b1);
    #1 NRST = 0;
    #1;
    chk1("rst_mid_valid", bus.BUS_VALID, 1'b0);
    chk1("rst_mid_tmo", BUS_TIMEOUT, 1'b0);
    chk1("rst_mid_busy", HCU_DMEM_BUSY, 1'b0);
    chk("rst_mid_addr", bus.BUS_ADDR, 32'h0);
    chk("rst_mid_irdata", IMEM_RDATA, 32'h13);
    chk("rst_mid_drdata", DMEM_RDATA, 32'h0);
    repeat (2) @(posedge CLK);
    #1 NRST = 1;
    ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk1("rst_no_done", HCU_DMEM_DONE, 1'b0);
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares a single external memory bus between the instruction-fetch port and the data load/store port of the pipelined RV32I core. It latches single-cycle request pulses and grants the bus with data priority plus an instruction-starvation guard. It drives the HCU busy/done signals consumed by the pipeline hazard control unit, and aborts any bus access that exceeds a timeout.

## Interface
- MAX_DSTREAK, 4: maximum consecutive data grants while an instruction fetch is pending.
- TIMEOUT, 255: bus-wait cycles before abort (8-bit counter).
- CLK  in  1  core clock.
- NRST  in  1  reset, asynchronous, active-low.
- IMEM_REQ  in  1  one-cycle fetch request pulse.
- IMEM_ADDR  in  32  fetch address, sampled with IMEM_REQ.
- IMEM_RDATA  out  32  fetched instruction.
- HCU_IMEM_BUSY  out  1  fetch outstanding.
- HCU_IMEM_DONE  out  1  one-cycle fetch completion.
- DMEM_REQ_LOAD  in  1  one-cycle load pulse (C_ISLOAD_SS).
- DMEM_REQ_STORE  in  1  one-cycle store pulse (C_ISSTORE_SS).
- DMEM_ADDR  in  32  data address.
- DMEM_WDATA  in  32  store data.
- DMEM_STRB  in  4  store byte strobes.
- DMEM_RDATA  out  32  load data.
- HCU_DMEM_BUSY  out  1  data access outstanding.
- HCU_DMEM_DONE  out  1  one-cycle data completion.
- BUS_VALID  out  1  access valid.
- BUS_WRITE  out  1  1 = store.
- BUS_ADDR  out  32  access address.
- BUS_WDATA  out  32  store data.
- BUS_STRB  out  4  strobes (4'b0 for reads).
- BUS_READY  in  1  slave accepts/completes the access.
- BUS_RDATA  in  32  read data, valid with BUS_READY.
- BUS_TIMEOUT  out  1  sticky abort flag.

## Operation
- Each port has a pending flag. A request pulse captures addr/wdata/strb/write into that port's latch and sets the flag. A pulse while the port is already pending is ignored.
- If DMEM_REQ_LOAD and DMEM_REQ_STORE arrive together, the store wins.
- HCU_x_BUSY = pending_x | request pulse_x (combinational, so the pipeline stalls in the request cycle).
- FSM states: IDLE, GNT_I, GNT_D.
  - Arbitration considers pending | pulse for each port.
  - Data wins unless an instruction is pending and dstreak ≥ MAX_DSTREAK, in which case the instruction is granted.
- dstreak (3-bit, saturating):
  - +1 on each data grant while an instruction is pending.
  - Cleared on an instruction grant, or when no instruction is pending.
- In GNT_x:
  - BUS_* is driven from latch x, and BUS_VALID is held with all BUS_* fields stable until BUS_VALID & BUS_READY (handshake).
  - On handshake, BUS_RDATA is registered into x_RDATA (reads only; stores leave DMEM_RDATA unchanged).
  - Also on handshake: pending_x clears, DONE_x pulses in the next cycle, and the FSM re-arbitrates directly, going to IDLE only if nothing is pending.
- Timeout:
  - A wait counter increments each GNT cycle without READY.
  - When it reaches TIMEOUT, BUS_VALID drops, x_RDATA is set to 32'hDEADBEEF, and DONE_x pulses next cycle.
  - BUS_TIMEOUT sets and stays set until reset.
  - The counter clears on every grant.

## Timing
- Reset values:
  - IMEM_RDATA = 32'h13 (NOP).
  - DMEM_RDATA = 0.
  - All BUS_*, DONE, BUSY, BUS_TIMEOUT = 0.
  - FSM = IDLE, dstreak = 0, pending flags = 0.
- Reset mid-access drops BUS_VALID asynchronously. No DONE is issued afterwards.
- Minimum latency:
  - Request pulse in cycle 0.
  - BUS_VALID in cycle 1.
  - READY in cycle 1 gives DONE and RDATA in cycle 2.
  - BUSY is high in cycles 0–1 and low from cycle 2.
- Back-to-back: if the other port is pending, its BUS_VALID rises in the cycle after the handshake. The bus has no idle bubble.
- x_RDATA holds its value until the next read completion on that port.
- A port may re-request in its DONE cycle.

## Structure
- Package core_mem_arb_pkg holds:
  - the FSM state encodings;
  - TIMEOUT_RDATA = 32'hDEADBEEF;
  - IMEM_RESET_RDATA = 32'h13.
- Sub-module core_mem_arb_req_latch (pending flag plus addr/wdata/strb/write capture), instantiated once per port.
- Arbitration, dstreak, timeout and RDATA registers live in the top.

## Test plan
- Single fetch, IMEM_ADDR=0x100, READY in the first VALID cycle:
  - BUS_VALID in cycle 1 with BUS_ADDR=0x100, BUS_WRITE=0.
  - HCU_IMEM_DONE in cycle 2 with IMEM_RDATA=BUS_RDATA.
- Simultaneous IMEM_REQ and DMEM_REQ_STORE (addr 0x2000, STRB=4'b0011):
  - Store is granted first.
  - Fetch VALID follows in the cycle after the store handshake.
  - DMEM_RDATA unchanged.
- Fetch pending during 6 consecutive loads: the fetch is granted after exactly 4 data grants.
- BUS_READY held low:
  - Abort after 255 wait cycles.
  - HCU_DMEM_DONE pulses with DMEM_RDATA=32'hDEADBEEF.
  - BUS_TIMEOUT stays 1 until reset.
- Protocol corners:
  - Second IMEM_REQ while pending: ignored, exactly one bus access.
  - LOAD and STORE in the same cycle: a single write access.
- NRST low during a stalled GNT_D:
  - BUS_VALID drops immediately and all outputs return to reset values.
  - No DONE pulse after release.
